vproc_mem_responder: RTL

//  Bus responder (target) for the VProc initiator interface: decodes one 256MB address segment,

---
 rtl/vproc_resp_pkg.sv | 26 ++
 rtl/vproc_resp_ram.sv | 22 ++
 rtl/vproc_mem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vproc_resp_pkg.sv
// Shared definitions for the VProc memory responder: FSM encodings, register
// indices and the WAITCFG field layout.
package vproc_resp_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [1:0] REG_WAITCFG = 2'd0;
    localparam logic [1:0] REG_WRCNT   = 2'd1;
    localparam logic [1:0] REG_RDCNT   = 2'd2;

    localparam int WCFG_RD_LSB = 0;
    localparam int WCFG_WR_LSB = 8;

    // Builds the WAITCFG read value from the two wait-state fields
    function automatic logic [31:0] waitcfg_pack(input logic [3:0] wr_wait,
                                                 input logic [3:0] rd_wait);
        logic [31:0] v;
        v = '0;
        v[WCFG_WR_LSB +: 4] = wr_wait;
        v[WCFG_RD_LSB +: 4] = rd_wait;
        return v;
    endfunction

endpackage

// File: rtl/vproc_resp_ram.sv
// Single-port synchronous 32-bit RAM with registered, read-before-write output.
module vproc_resp_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    // Contents are deliberately not reset; rdata always shows the pre-write word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vproc_mem_responder.sv
// VProc bus target: one address segment mapping a RAM and a small register
// space, acknowledging each access after a programmable number of wait states.
module vproc_mem_responder
    import vproc_resp_pkg::*;
#(
    parameter logic [3:0] SEGMENT    = 4'ha,
    parameter int         ADDR_WIDTH = 10,
    parameter logic [3:0] RD_WAIT    = 4'd2,
    parameter logic [3:0] WR_WAIT    = 4'd1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    output logic        WRAck,
    output logic        RDAck
);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [3:0]            wr_wait;
    logic [3:0]            rd_wait;
    logic [31:0]           wr_count;
    logic [31:0]           rd_count;
    logic                  lat_we;
    logic                  lat_rd;
    logic                  lat_reg;
    logic [1:0]            lat_reg_idx;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_data;

    logic                  sel;
    logic                  finish;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_rdata;
    logic [31:0]           reg_rdata;
    logic                  unused_addr;

    assign sel    = (Addr[31:28] == SEGMENT) && (WE || RD);
    assign finish = (state == S_WAIT) && (cnt == 4'd0);
    assign ram_we = finish && lat_we && !lat_reg;

    // In IDLE the RAM looks at the live address so a zero-wait read has data ready
    assign ram_addr    = (state == S_IDLE) ? Addr[ADDR_WIDTH+1:2] : lat_idx;
    assign unused_addr = ^{Addr[26:ADDR_WIDTH+2], Addr[1:0]};

    vproc_resp_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(lat_data),
        .rdata(ram_rdata)
    );

    always_comb begin
        reg_rdata = '0;
        case (lat_reg_idx)
            REG_WAITCFG: reg_rdata = waitcfg_pack(wr_wait, rd_wait);
            REG_WRCNT:   reg_rdata = wr_count;
            REG_RDCNT:   reg_rdata = rd_count;
            default:     reg_rdata = '0;
        endcase
    end

    // Access completes on the edge that enters ACK: write, read capture, counters, acks
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            wr_wait     <= WR_WAIT;
            rd_wait     <= RD_WAIT;
            wr_count    <= '0;
            rd_count    <= '0;
            lat_we      <= 1'b0;
            lat_rd      <= 1'b0;
            lat_reg     <= 1'b0;
            lat_reg_idx <= '0;
            lat_idx     <= '0;
            lat_data    <= '0;
            DataIn      <= '0;
            WRAck       <= 1'b0;
            RDAck       <= 1'b0;
        end else begin
            WRAck <= 1'b0;
            RDAck <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel) begin
                        lat_we      <= WE;
                        lat_rd      <= RD;
                        lat_reg     <= Addr[27];
                        lat_reg_idx <= Addr[3:2];
                        lat_idx     <= Addr[ADDR_WIDTH+1:2];
                        lat_data    <= DataOut;
                        cnt         <= WE ? wr_wait : rd_wait;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_ACK;
                        WRAck <= lat_we;
                        RDAck <= lat_rd;
                        if (lat_rd) begin
                            DataIn <= lat_reg ? reg_rdata : ram_rdata;
                        end
                        if (!lat_reg && lat_we) begin
                            wr_count <= wr_count + 32'd1;
                        end
                        if (!lat_reg && lat_rd) begin
                            rd_count <= rd_count + 32'd1;
                        end
                        if (lat_reg && lat_we && (lat_reg_idx == REG_WAITCFG)) begin
                            wr_wait <= lat_data[WCFG_WR_LSB +: 4];
                            rd_wait <= lat_data[WCFG_RD_LSB +: 4];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
